// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared defaults, FSM encoding and port indices for dmem_arbiter.
package dmem_arb_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} arbState_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select; round-robin under DMEM_ARB_RR_EN, else fixed port-0 priority.
module dmem_arb_pick (
    input  logic req0,
    input  logic req1,
`ifdef DMEM_ARB_RR_EN
    input  logic lastServed,
`endif
    output logic gnt0,
    output logic gnt1
);
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        gnt0 = req0 & (~req1 | lastServed);
`else
        gnt0 = req0;
`endif
        gnt1 = req1 & ~gnt0;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory with a registered access stage.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0,
    input  logic              We0,
    input  logic [31:0]       Addr0,
    input  logic [DATA_W-1:0] WrData0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [31:0]       Addr1,
    input  logic [DATA_W-1:0] WrData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic [DATA_W-1:0] RdData0,
    output logic [DATA_W-1:0] RdData1,
    output logic              RdValid0,
    output logic              RdValid1,
    output logic              Err0,
    output logic              Err1,
    output logic [31:0]       DmemAddr,
    output logic              DmemWrite,
    output logic [DATA_W-1:0] DmemWrData,
    input  logic [DATA_W-1:0] DmemRdData
);
    arbState_t         state, nextState;
    logic              pickGnt0, pickGnt1, anyReq;
    logic              selPort, selWe, selOor;
    logic [31:0]       selAddr;
    logic [DATA_W-1:0] selData;
    logic              accOwner, accRead, accErr, doRead, doErr;
`ifdef DMEM_ARB_RR_EN
    logic              lastServed;
`endif

    dmem_arb_pick uPick (
        .req0       (Req0),
        .req1       (Req1),
`ifdef DMEM_ARB_RR_EN
        .lastServed (lastServed),
`endif
        .gnt0       (pickGnt0),
        .gnt1       (pickGnt1)
    );

    // Grants are masked during reset so nothing is offered while the stage is held clear.
    always_comb begin
        anyReq    = Req0 | Req1;
        Gnt0      = pickGnt0 & Rst_n;
        Gnt1      = pickGnt1 & Rst_n;
        nextState = anyReq ? ACCESS : IDLE;
        selPort   = pickGnt1 ? PORT1 : PORT0;
        selWe     = (selPort == PORT1) ? We1 : We0;
        selAddr   = (selPort == PORT1) ? Addr1 : Addr0;
        selData   = (selPort == PORT1) ? WrData1 : WrData0;
        selOor    = |selAddr[31:ADDR_W];
        doRead    = (state == ACCESS) & accRead;
        doErr     = (state == ACCESS) & accErr;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            lastServed <= PORT1;
        else if (anyReq)
            lastServed <= selPort;
    end
`endif

    // Write strobe is a flop so an asynchronous reset kills a pending write at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            accOwner   <= PORT0;
            accRead    <= 1'b0;
            accErr     <= 1'b0;
            DmemAddr   <= '0;
            DmemWrite  <= 1'b0;
            DmemWrData <= '0;
            RdData0    <= '0;
            RdData1    <= '0;
            RdValid0   <= 1'b0;
            RdValid1   <= 1'b0;
            Err0       <= 1'b0;
            Err1       <= 1'b0;
        end else begin
            DmemWrite <= anyReq & selWe & ~selOor;
            if (anyReq) begin
                accOwner   <= selPort;
                accRead    <= ~selWe & ~selOor;
                accErr     <= selOor;
                DmemAddr   <= selAddr;
                DmemWrData <= selData;
            end
            RdValid0 <= doRead & (accOwner == PORT0);
            RdValid1 <= doRead & (accOwner == PORT1);
            Err0     <= doErr & (accOwner == PORT0);
            Err1     <= doErr & (accOwner == PORT1);
            if (doRead && accOwner == PORT0)
                RdData0 <= DmemRdData;
            if (doRead && accOwner == PORT1)
                RdData1 <= DmemRdData;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 256x32 behavioural memory.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        Clk, Rst_n, initMem;
    logic        Req0, We0, Req1, We1;
    logic [31:0] Addr0, Addr1, WrData0, WrData1;
    logic        Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1, DmemWrite;
    logic [31:0] RdData0, RdData1, DmemAddr, DmemWrData, DmemRdData;
    logic [31:0] mem [256];
    logic        expG [6];
    logic [7:0]  cnt0, cnt1;
    int          total = 0;
    int          bad = 0;

    dmem_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WrData0(WrData0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .WrData1(WrData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .RdData0(RdData0), .RdData1(RdData1),
        .RdValid0(RdValid0), .RdValid1(RdValid1),
        .Err0(Err0), .Err1(Err1),
        .DmemAddr(DmemAddr), .DmemWrite(DmemWrite), .DmemWrData(DmemWrData),
        .DmemRdData(DmemRdData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        if (initMem)
            for (int i = 0; i < 256; i++) mem[i] <= (i == 9) ? 32'hAA : 32'h1000 + 32'(i);
        else if (DmemWrite)
            mem[DmemAddr[7:0]] <= DmemWrData;
    end
    assign DmemRdData = mem[DmemAddr[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        initMem = 1'b1; Rst_n = 1'b0;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'd1; WrData0 = '0;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'd2; WrData1 = '0;
        cnt0 = '0; cnt1 = '0;
        repeat (3) step();
        Req0 = 1'b0; #1; Req0 = 1'b1; Req1 = 1'b0; #1; Req1 = 1'b1; #1;
        chk("rst_gnt", {Gnt0, Gnt1}, 2'b00);
        chk("rst_flags", {RdValid0, RdValid1, Err0, Err1, DmemWrite}, 5'b0);
        chk("rst_addr", DmemAddr, 32'h0);
        chk("rst_wrdata", DmemWrData, 32'h0);
        chk("rst_rddata", {RdData0, RdData1}, 64'h0);
        step();
        initMem = 1'b0; Rst_n = 1'b1; #1;
        chk("first_gnt", {Gnt0, Gnt1}, 2'b10);
        Req0 = 1'b0; Req1 = 1'b0;
        step();
        // port 0 write then read-back
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'd5; WrData0 = 32'hDEADBEEF; #1;
        chk("wr5_gnt", {Gnt0, Gnt1}, 2'b10);
        step();
        chk("wr5_we", DmemWrite, 1'b1);
        chk("wr5_addr", DmemAddr, 32'd5);
        chk("wr5_data", DmemWrData, 32'hDEADBEEF);
        We0 = 1'b0; #1;
        chk("rd5_gnt", {Gnt0, Gnt1}, 2'b10);
        step();
        chk("rd5_drive", {DmemWrite, RdValid0}, 2'b00);
        Req0 = 1'b0;
        step();
        chk("rd5_valid", {RdValid0, RdValid1, Gnt1}, 3'b100);
        chk("rd5_data", RdData0, 32'hDEADBEEF);
        step();
        chk("rd5_hold", {RdValid0, RdData0}, {1'b0, 32'hDEADBEEF});
        // fresh reset, then sustained dual reads
        Rst_n = 1'b0; #1; Rst_n = 1'b1;
        Req0 = 1'b1; Req1 = 1'b1; We0 = 1'b0; We1 = 1'b0; Addr0 = 32'd5; Addr1 = 32'd6;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin Req0 = 1'b0; Req1 = 1'b0; end
            #1;
            if (i < 6) begin
                expG[i] = RR & i[0];
                chk("dual_gnt", {Gnt0, Gnt1}, expG[i] ? 2'b01 : 2'b10);
                cnt0 += {7'b0, Gnt0};
                cnt1 += {7'b0, Gnt1};
            end else
                chk("dual_idle_gnt", {Gnt0, Gnt1}, 2'b00);
            if (i >= 2) begin
                chk("dual_valid", {RdValid0, RdValid1}, expG[i-2] ? 2'b01 : 2'b10);
                chk("dual_data", expG[i-2] ? RdData1 : RdData0, expG[i-2] ? 32'h1006 : 32'hDEADBEEF);
            end else
                chk("dual_valid_early", {RdValid0, RdValid1}, 2'b00);
            step();
        end
        chk("dual_cnt", {cnt0, cnt1}, RR ? 16'h0303 : 16'h0600);
        // out-of-range write from port 1
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 32'd300; WrData1 = 32'h55; #1;
        chk("oor_gnt", {Gnt0, Gnt1}, 2'b01);
        step();
        chk("oor_we", DmemWrite, 1'b0);
        chk("oor_addr", DmemAddr, 32'd300);
        Req1 = 1'b0;
        step();
        chk("oor_err", {Err0, Err1, RdValid0, RdValid1}, 4'b0100);
        chk("oor_rddata", RdData1, RR ? 32'h1006 : 32'h0);
        step();
        chk("oor_err_end", {Err0, Err1}, 2'b00);
        chk("oor_mem44", mem[44], 32'h102C);
        // read-after-write across ports
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'd7; WrData0 = 32'h11; #1;
        chk("raw_wr_gnt", {Gnt0, Gnt1}, 2'b10);
        step();
        Req0 = 1'b0; Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'd7; #1;
        chk("raw_rd_gnt", {Gnt0, Gnt1}, 2'b01);
        step();
        Req1 = 1'b0;
        step();
        chk("raw_valid", {RdValid0, RdValid1}, 2'b01);
        chk("raw_data", RdData1, 32'h11);
        // reset during the access cycle of a write
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'd9; WrData0 = 32'hBB; #1;
        step();
        chk("rstmid_we", DmemWrite, 1'b1);
        Req0 = 1'b0; #2;
        Rst_n = 1'b0; #1;
        chk("rstmid_drop", DmemWrite, 1'b0);
        step();
        Rst_n = 1'b1;
        step();
        chk("rstmid_flags", {RdValid0, RdValid1, Err0, Err1}, 4'b0);
        step();
        chk("rstmid_flags2", {RdValid0, RdValid1, Err0, Err1}, 4'b0);
        chk("rstmid_mem9", mem[9], 32'hAA);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 256×32 data memory between two requesters, e.g. CPU load/store unit (port 0) and a DMA/debug engine (port 1). It sits between the requesters and the data memory. It owns the memory's address, write-enable and write-data inputs, and consumes the memory's combinational read data. Each accepted request is captured into a registered access stage, so one access completes per cycle. Read data returns to the winning port with a valid pulse.

## Interface
- ADDR_W, 8: word-address bits the memory implements; valid word addresses are 0..2^ADDR_W-1.
- DATA_W, 32: data width.
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Req0 / Req1  in  1  access request; must hold with Addr/We/WrData stable until Gnt seen at a rising edge.
- We0 / We1  in  1  1 = write, 0 = read.
- Addr0 / Addr1  in  32  word address.
- WrData0 / WrData1  in  DATA_W  write data.
- Gnt0 / Gnt1  out  1  combinational; high in the cycle the request is accepted at the next edge.
- RdData0 / RdData1  out  DATA_W  registered read data, held until the next read completes on that port.
- RdValid0 / RdValid1  out  1  one-cycle pulse, read data valid.
- Err0 / Err1  out  1  one-cycle pulse, address out of range.
- DmemAddr  out  32  to memory, registered.
- DmemWrite  out  1  to memory, registered.
- DmemWrData  out  DATA_W  to memory, registered.
- DmemRdData  in  DATA_W  from memory, combinational.

## Operation
- States: IDLE (no access stage) and ACCESS (access stage holds one request; owner, we, addr and data registered).
- Every cycle in either state, if any Req is high, exactly one Gnt is high. At the edge, the request is loaded into the access stage and the state becomes ACCESS. With no Req, the state becomes IDLE.
- Selection with one requester: that port. With both requesters: see Configuration.
- In ACCESS with an in-range write, DmemWrite=1 and the memory writes at the closing edge. For a read, DmemWrite=0 and DmemRdData is captured into RdData of the owner at the closing edge.
- Out-of-range (Addr[31:ADDR_W] != 0): the access stage is loaded but DmemWrite is forced 0. Err of the owner pulses the next cycle, no RdValid, and RdData is unchanged.
- In IDLE, DmemWrite=0. DmemAddr/DmemWrData hold their last values.
- Reset values: Gnt 0, RdData 0, RdValid 0, Err 0, DmemAddr 0, DmemWrite 0, DmemWrData 0, state IDLE, last-served = port 1 (so port 0 wins first).
- Reset mid-access: DmemWrite drops immediately (asynchronously). The pending write is lost and no RdValid/Err is issued.

## Timing
- Request accepted at edge E0 (Gnt high in the cycle before E0).
- Memory is driven during E0→E1. The write commits at E1.
- RdValid/Err are high during E1→E2 with RdData valid.
- Throughput: one access per cycle, back-to-back, with no bubble.
- Read-after-write to the same address from either port in consecutive cycles returns the new data.
- Gnt never asserts without the matching Req. Gnt0 & Gnt1 is never 1.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On a conflict, the port not served by the most recent grant wins, so sustained dual requests alternate 0,1,0,1.
- DMEM_ARB_RR_EN not defined: fixed priority, port 0 always wins and port 1 can starve. The last-served register is removed.

## Structure
- Package dmem_arb_pkg: ADDR_W/DATA_W defaults, state encoding (IDLE, ACCESS), port index constants.
- One sub-module, dmem_arb_pick: combinational winner select from {Req1, Req0, last_served}, compiled per DMEM_ARB_RR_EN.

## Test plan
- Reset: hold Rst_n=0, toggle Req0/Req1 → all outputs 0. After release, with both Req, Gnt0 is first.
- Port 0 writes 0xDEADBEEF to addr 5 at E0, then reads addr 5 → RdValid0 at E2→E3 with RdData0=0xDEADBEEF. Gnt1 and RdValid1 stay 0.
- Both ports hold read requests for 6 cycles → RR: grants 0,1,0,1,0,1, each RdValid one cycle after its access. Without the macro: six Gnt0, zero Gnt1.
- Port 1 writes addr 300 → Gnt1, DmemWrite stays 0, Err1 pulses one cycle, and memory addr 300 mod 256 = 44 is unchanged.
- Port 0 writes 0x11 to addr 7, and in the next cycle port 1 reads addr 7 → RdData1=0x11.
- Assert Rst_n low during the ACCESS cycle of a write to addr 9 (old 0xAA) → DmemWrite drops asynchronously, addr 9 still 0xAA, and no RdValid/Err follows.
